sz_fir: RTL and testbench

SZ_FIR -- requirements
Module: sz_fir

---
 rtl/sz_fir_pkg.sv | 17 +
 rtl/sz_fir_if.sv | 23 ++
 rtl/sz_fir_mac.sv | 50 +++++
 rtl/sz_fir.sv | 95 +++++++++
 tb/tb_sz_fir.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sz_fir_pkg.sv
// Shared constants and FSM state type for the filtered-x (sz path) FIR.
package sz_fir_pkg;
  localparam int unsigned TAPS_DEF      = 126;
  localparam int unsigned OUT_SHIFT_DEF = 19;
  localparam int unsigned ACC_W         = 43;
  localparam int unsigned PROD_W        = 36;
  localparam int unsigned X_W           = 16;
  localparam int unsigned COEF_W        = 20;
  localparam int unsigned ADDR_W        = 7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;
endpackage

// File: rtl/sz_fir_if.sv
// Signal bundle for the sz_fir audio/sz_ram side; master drives the DUT inputs.
interface sz_fir_if;
  import sz_fir_pkg::*;
  logic                     audio_rx_down;
  logic signed [X_W-1:0]    xn;
  logic                     ofz_ok;
  logic [ADDR_W-1:0]        sz_addr;
  logic signed [COEF_W-1:0] sz;
  logic signed [X_W-1:0]    xf;
  logic                     xf_valid;
  logic                     busy;
  logic                     overrun;

  modport master (
    output audio_rx_down, xn, ofz_ok, sz,
    input  sz_addr, xf, xf_valid, busy, overrun
  );

  modport slave (
    input  audio_rx_down, xn, ofz_ok, sz,
    output sz_addr, xf, xf_valid, busy, overrun
  );
endinterface

// File: rtl/sz_fir_mac.sv
// sz_mac: registered tap x coefficient product feeding a clearable accumulator.
// SZ_FIR_SAT_EN selects a saturating 16-bit result instead of plain truncation.
module sz_mac
  import sz_fir_pkg::*;
#(
  parameter int unsigned OUT_SHIFT = OUT_SHIFT_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     prod_en,
  input  logic signed [X_W-1:0]    tap,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [X_W-1:0]    result
);
  localparam int unsigned SH_W = ACC_W - OUT_SHIFT;

  logic signed [PROD_W-1:0] prod;
  logic                     prod_vld;
  logic signed [ACC_W-1:0]  acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
    end else begin
      prod_vld <= prod_en;
      if (prod_en) prod <= tap * coef;
      if (clear) acc <= '0;
      else if (prod_vld) acc <= acc + ACC_W'(prod);
    end
  end

`ifdef SZ_FIR_SAT_EN
  localparam logic signed [SH_W-1:0] MAX_V = SH_W'(32767);
  localparam logic signed [SH_W-1:0] MIN_V = SH_W'(-32768);

  logic signed [SH_W-1:0] shifted;
  assign shifted = SH_W'(acc >>> OUT_SHIFT);

  always_comb begin
    result = X_W'(shifted);
    if (shifted > MAX_V)      result = 16'sh7fff;
    else if (shifted < MIN_V) result = 16'sh8000;
  end
`else
  assign result = X_W'(acc >>> OUT_SHIFT);
`endif
endmodule

// File: rtl/sz_fir.sv
// Filtered-x FIR: convolves the reference xn with the sz_ram path estimate, one tap per cycle.
// Define SZ_FIR_SAT_EN to saturate xf instead of wrapping.
module sz_fir
  import sz_fir_pkg::*;
#(
  parameter int unsigned TAPS      = TAPS_DEF,
  parameter int unsigned OUT_SHIFT = OUT_SHIFT_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     audio_rx_down,
  input  logic signed [X_W-1:0]    xn,
  input  logic                     ofz_ok,
  output logic [ADDR_W-1:0]        sz_addr,
  input  logic signed [COEF_W-1:0] sz,
  output logic signed [X_W-1:0]    xf,
  output logic                     xf_valid,
  output logic                     busy,
  output logic                     overrun
);
  state_t                  state, state_nxt;
  logic [1:0]              drain_cnt;
  logic [ADDR_W-1:0]       ptr;
  logic signed [X_W-1:0]   line [TAPS];
  logic signed [X_W-1:0]   tap_q;
  logic                    sz_vld;
  logic signed [X_W-1:0]   mac_result;
  logic signed [X_W-1:0]   xf_hold;
  logic [ADDR_W:0]         rd_idx;
  logic                    take;
  logic                    start;

  assign take  = (state == S_IDLE) && audio_rx_down;
  assign start = take && ofz_ok;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (sz_addr == ADDR_W'(TAPS)) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_cnt == 2'd1) state_nxt = S_OUT;
      S_OUT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Newest sample sits at ptr-1, so address k reads x[n-(k-1)] at (ptr-k) mod TAPS.
  always_comb begin
    if ({1'b0, ptr} >= {1'b0, sz_addr}) rd_idx = {1'b0, ptr} - {1'b0, sz_addr};
    else                                rd_idx = {1'b0, ptr} + (ADDR_W+1)'(TAPS) - {1'b0, sz_addr};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
      sz_addr   <= '0;
      ptr       <= '0;
      tap_q     <= '0;
      sz_vld    <= 1'b0;
      xf_hold   <= '0;
      overrun   <= 1'b0;
      for (int unsigned i = 0; i < TAPS; i++) line[i] <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 2'd1 : '0;
      if (state_nxt == S_RUN) sz_addr <= (state == S_RUN) ? sz_addr + 1'b1 : ADDR_W'(1);
      else                    sz_addr <= '0;
      if (take) begin
        line[ptr] <= xn;
        ptr       <= (ptr == ADDR_W'(TAPS - 1)) ? '0 : ptr + 1'b1;
      end
      // Tap is delayed one cycle to line up with sz, which arrives one cycle after sz_addr.
      tap_q  <= line[rd_idx[ADDR_W-1:0]];
      sz_vld <= (state == S_RUN);
      if (state == S_OUT) xf_hold <= mac_result;
      if (audio_rx_down && (state != S_IDLE)) overrun <= 1'b1;
    end
  end

  sz_mac #(.OUT_SHIFT(OUT_SHIFT)) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start),
    .prod_en (sz_vld),
    .tap     (tap_q),
    .coef    (sz),
    .result  (mac_result)
  );

  // Final product lands in the accumulator on the OUT cycle, so xf is presented from it directly.
  assign xf       = (state == S_OUT) ? mac_result : xf_hold;
  assign xf_valid = (state == S_OUT);
  assign busy     = (state != S_IDLE);
endmodule

// File: tb/tb_sz_fir.sv
// Self-checking bench for sz_fir against a sum-of-products reference over a sample history queue.
module tb_sz_fir;
  localparam int TAPS      = 126;
  localparam int OUT_SHIFT = 19;
  localparam int LAT       = TAPS + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  sz_fir_if bus();

  logic signed [19:0] coef [0:TAPS];
  int hist[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sz_fir #(.TAPS(TAPS), .OUT_SHIFT(OUT_SHIFT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .audio_rx_down (bus.audio_rx_down),
    .xn            (bus.xn),
    .ofz_ok        (bus.ofz_ok),
    .sz_addr       (bus.sz_addr),
    .sz            (bus.sz),
    .xf            (bus.xf),
    .xf_valid      (bus.xf_valid),
    .busy          (bus.busy),
    .overrun       (bus.overrun)
  );

  // sz_ram model: data valid one cycle after the address
  always @(posedge clk) begin
    if (bus.sz_addr >= 1 && int'(bus.sz_addr) <= TAPS) bus.sz <= coef[bus.sz_addr];
    else bus.sz <= '0;
  end

  function automatic logic signed [15:0] model_xf();
    longint sum = 0;
    longint sh;
    for (int k = 1; k <= TAPS; k++)
      if (k - 1 < hist.size()) sum += longint'(coef[k]) * longint'(hist[k-1]);
    sh = sum >>> OUT_SHIFT;
`ifdef SZ_FIR_SAT_EN
    if (sh > 32767) sh = 32767;
    else if (sh < -32768) sh = -32768;
`endif
    return 16'(sh);
  endfunction

  task automatic push_hist(input logic signed [15:0] x);
    hist.push_front(int'(x));
    if (hist.size() > TAPS) void'(hist.pop_back());
  endtask

  task automatic set_coef_zero();
    for (int k = 0; k <= TAPS; k++) coef[k] = '0;
  endtask

  task automatic set_coef_random();
    coef[0] = '0;
    for (int k = 1; k <= TAPS; k++) coef[k] = 20'($urandom);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.audio_rx_down = 1'b0;
    repeat (2) @(negedge clk);
    hist.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One strobe with ofz_ok high; returns xf at the pulse, its latency, pulse count and hold status.
  task automatic run_sample(input logic signed [15:0] x, output logic signed [15:0] got,
                            output int lat, output int pulses, output bit held);
    @(negedge clk);
    bus.xn = x;
    bus.audio_rx_down = 1'b1;
    push_hist(x);
    @(negedge clk);
    bus.audio_rx_down = 1'b0;
    lat = 1;
    while (!bus.xf_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.xf_valid) lat = -1;
    got = bus.xf;
    pulses = bus.xf_valid ? 1 : 0;
    held = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.xf_valid) pulses++;
      if (bus.xf !== got) held = 1'b0;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({bus.xf, bus.xf_valid, bus.sz_addr, bus.busy, bus.overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: xf=%0d xf_valid=%b sz_addr=%0d busy=%b overrun=%b, required all 0",
               bus.xf, bus.xf_valid, bus.sz_addr, bus.busy, bus.overrun);
    end
  endtask

  task automatic test_identity();
    logic signed [15:0] got;
    int lat, pulses;
    bit held;
    apply_reset();
    set_coef_zero();
    coef[1] = 20'sd524287;
    run_sample(16'sd1000, got, lat, pulses, held);
    n_checks++;
    if (lat !== LAT) begin n_fail++; $display("FAIL identity_latency: got %0d required %0d", lat, LAT); end
    n_checks++;
    if (got !== 16'sd999) begin n_fail++; $display("FAIL identity_xf: got %0d required 999", got); end
    n_checks++;
    if (pulses !== 1) begin n_fail++; $display("FAIL identity_pulses: got %0d required 1", pulses); end
    n_checks++;
    if (held !== 1'b1) begin n_fail++; $display("FAIL identity_hold: xf not held after pulse, required held"); end
  endtask

  task automatic test_delay();
    logic signed [15:0] got;
    logic signed [15:0] exp_v [3];
    logic signed [15:0] xin [3];
    int lat, pulses;
    bit held;
    exp_v = '{16'sd0, 16'sd0, 16'sd1000};
    xin   = '{16'sd2000, 16'sd0, 16'sd0};
    apply_reset();
    set_coef_zero();
    coef[3] = 20'sd262144;
    for (int i = 0; i < 3; i++) begin
      run_sample(xin[i], got, lat, pulses, held);
      n_checks++;
      if (got !== exp_v[i]) begin
        n_fail++;
        $display("FAIL delay_xf[%0d]: got %0d required %0d", i, got, exp_v[i]);
      end
    end
  endtask

  task automatic test_random();
    logic signed [15:0] got, exp_xf;
    int lat, pulses;
    bit held;
    apply_reset();
    set_coef_random();
    for (int i = 0; i < 8; i++) begin
      run_sample(16'($urandom), got, lat, pulses, held);
      exp_xf = model_xf();
      n_checks++;
      if (got !== exp_xf || lat !== LAT) begin
        n_fail++;
        $display("FAIL random_xf[%0d]: got %0d (lat %0d) required %0d (lat %0d)", i, got, lat, exp_xf, LAT);
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [15:0] got, exp_xf;
    logic signed [15:0] exp_final;
    int lat, pulses;
    bit held;
`ifdef SZ_FIR_SAT_EN
    exp_final = 16'sd32767;
`else
    exp_final = -16'sd134;
`endif
    apply_reset();
    coef[0] = '0;
    for (int k = 1; k <= TAPS; k++) coef[k] = 20'sd524287;
    for (int i = 0; i < TAPS; i++) begin
      run_sample(16'sd32767, got, lat, pulses, held);
      exp_xf = model_xf();
      n_checks++;
      if (got !== exp_xf) begin
        n_fail++;
        $display("FAIL sat_xf[%0d]: got %0d required %0d", i, got, exp_xf);
      end
    end
    n_checks++;
    if (got !== exp_final) begin n_fail++; $display("FAIL sat_final: got %0d required %0d", got, exp_final); end
  endtask

  task automatic test_overrun();
    logic signed [15:0] got, exp_xf;
    int lat, pulses, cyc;
    bit held;
    apply_reset();
    set_coef_random();
    for (int i = 0; i < 3; i++) run_sample(16'($urandom), got, lat, pulses, held);
    n_checks++;
    if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_idle: got %b required 0", bus.overrun); end
    @(negedge clk);
    bus.xn = 16'sd12345;
    bus.audio_rx_down = 1'b1;
    push_hist(16'sd12345);
    exp_xf = model_xf();
    @(negedge clk);
    bus.audio_rx_down = 1'b0;
    cyc = 1;
    while (!bus.xf_valid && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 50) bus.audio_rx_down = 1'b1;
      if (cyc == 50) bus.xn = -16'sd7777;
      if (cyc == 51) bus.audio_rx_down = 1'b0;
    end
    n_checks++;
    if (cyc !== LAT || bus.xf !== exp_xf) begin
      n_fail++;
      $display("FAIL overrun_result: got %0d at cycle %0d required %0d at cycle %0d", bus.xf, cyc, exp_xf, LAT);
    end
    n_checks++;
    if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_flag: got %b required 1", bus.overrun); end
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.xf_valid) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin n_fail++; $display("FAIL overrun_extra_pulse: got %0d required 0", pulses); end
    run_sample(16'sd321, got, lat, pulses, held);
    exp_xf = model_xf();
    n_checks++;
    if (got !== exp_xf) begin n_fail++; $display("FAIL overrun_next: got %0d required %0d", got, exp_xf); end
    n_checks++;
    if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b required 1", bus.overrun); end
  endtask

  task automatic test_gating();
    logic signed [15:0] got, exp_xf;
    logic signed [15:0] x;
    int lat, pulses, viol, cyc;
    bit held;
    apply_reset();
    set_coef_random();
    bus.ofz_ok = 1'b0;
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      x = 16'($urandom);
      bus.xn = x;
      bus.audio_rx_down = 1'b1;
      push_hist(x);
      repeat (4) begin
        @(negedge clk);
        bus.audio_rx_down = 1'b0;
        if (bus.xf_valid || bus.sz_addr != 0 || bus.busy) viol++;
      end
    end
    n_checks++;
    if (viol !== 0) begin n_fail++; $display("FAIL gating_idle: got %0d active cycles required 0", viol); end
    bus.ofz_ok = 1'b1;
    run_sample(16'($urandom), got, lat, pulses, held);
    exp_xf = model_xf();
    n_checks++;
    if (got !== exp_xf || lat !== LAT) begin
      n_fail++;
      $display("FAIL gating_buffered: got %0d (lat %0d) required %0d (lat %0d)", got, lat, exp_xf, LAT);
    end
    // ofz_ok falling mid-run must not abort the computation
    @(negedge clk);
    x = 16'($urandom);
    bus.xn = x;
    bus.audio_rx_down = 1'b1;
    push_hist(x);
    exp_xf = model_xf();
    @(negedge clk);
    bus.audio_rx_down = 1'b0;
    cyc = 1;
    while (!bus.xf_valid && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 20) bus.ofz_ok = 1'b0;
    end
    n_checks++;
    if (cyc !== LAT || bus.xf !== exp_xf) begin
      n_fail++;
      $display("FAIL gating_ofz_fall: got %0d at cycle %0d required %0d at cycle %0d", bus.xf, cyc, exp_xf, LAT);
    end
    bus.ofz_ok = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic signed [15:0] got, exp_xf;
    int lat, pulses;
    bit held;
    apply_reset();
    set_coef_random();
    for (int i = 0; i < 4; i++) run_sample(16'($urandom), got, lat, pulses, held);
    @(negedge clk);
    bus.xn = 16'sd5000;
    bus.audio_rx_down = 1'b1;
    @(negedge clk);
    bus.audio_rx_down = 1'b0;
    for (int c = 2; c <= 60; c++) begin
      @(negedge clk);
      bus.audio_rx_down = (c == 30);
    end
    bus.audio_rx_down = 1'b0;
    n_checks++;
    if (bus.overrun !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pre: overrun=%b busy=%b required 1 1", bus.overrun, bus.busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.xf, bus.xf_valid, bus.sz_addr, bus.busy, bus.overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: xf=%0d xf_valid=%b sz_addr=%0d busy=%b overrun=%b, required all 0",
               bus.xf, bus.xf_valid, bus.sz_addr, bus.busy, bus.overrun);
    end
    repeat (2) @(negedge clk);
    hist.delete();
    rst_n = 1'b1;
    run_sample(16'($urandom), got, lat, pulses, held);
    exp_xf = model_xf();
    n_checks++;
    if (got !== exp_xf || lat !== LAT) begin
      n_fail++;
      $display("FAIL reset_mid_clean: got %0d (lat %0d) required %0d (lat %0d)", got, lat, exp_xf, LAT);
    end
  endtask

  initial begin
    bus.audio_rx_down = 1'b0;
    bus.xn = '0;
    bus.ofz_ok = 1'b1;
    set_coef_zero();
    test_reset();
    test_identity();
    test_delay();
    test_random();
    test_saturation();
    test_overrun();
    test_gating();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
